// File: rtl/iqueue_tbp_pkg.sv
// Shared datapath types for the instruction queue.
package iqueue_tbp_pkg;

    localparam int unsigned IQ_WORD_W = 32;
    localparam int unsigned IQ_DEPTH  = 4;

    typedef logic [IQ_WORD_W-1:0] word_t;

    typedef enum logic {
        RUN    = 1'b0,
        FILTER = 1'b1
    } iq_state_t;

endpackage

// File: rtl/iqueue_tbp_if.sv
// Fetch-side, decode-side and redirect signals of the instruction queue.
interface iqueue_tbp_if
    import iqueue_tbp_pkg::*;
#(
    parameter int unsigned DEPTH  = IQ_DEPTH,
    parameter int unsigned WORD_W = IQ_WORD_W
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              f_valid;
    logic [WORD_W-1:0] f_instr;
    logic [WORD_W-1:0] f_pc;
    logic              f_ready;
    logic              d_valid;
    logic [WORD_W-1:0] d_instr;
    logic [WORD_W-1:0] d_pc;
    logic              d_ready;
    logic              flush;
    logic [WORD_W-1:0] flush_pc;
    logic [CNT_W-1:0]  count;

    // Fetch/decode/redirect side.
    modport master (
        output f_valid, f_instr, f_pc, d_ready, flush, flush_pc,
        input  f_ready, d_valid, d_instr, d_pc, count
    );

    // Queue side.
    modport slave (
        input  f_valid, f_instr, f_pc, d_ready, flush, flush_pc,
        output f_ready, d_valid, d_instr, d_pc, count
    );

endinterface

// File: rtl/iq_mem.sv
// Entry storage: register array with one write port and one async read port.
module iq_mem #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents need no reset since occupancy is tracked elsewhere.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/iqueue_tbp.sv
// Instruction queue between fetch and decode with flush-and-filter redirect.
module iqueue_tbp
    import iqueue_tbp_pkg::*;
#(
    parameter int unsigned DEPTH  = IQ_DEPTH,
    parameter int unsigned WORD_W = IQ_WORD_W
) (
    input logic          clk,
    input logic          rst,
    iqueue_tbp_if.slave  q
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    iq_state_t         state, state_nx;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0]  count_r, count_nx;
    logic [WORD_W-1:0] target, target_nx;
    logic              push;
    logic              pop;
    logic              ready;
    logic              valid;
    logic [2*WORD_W-1:0] rd_data;

    // State register, pointers, occupancy and redirect target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            target  <= '0;
        end else begin
            state   <= state_nx;
            wr_ptr  <= wr_ptr_nx;
            rd_ptr  <= rd_ptr_nx;
            count_r <= count_nx;
            target  <= target_nx;
        end
    end

    // Handshakes, next state and pointer updates; flush overrides everything.
    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        rd_ptr_nx = rd_ptr;
        count_nx  = count_r;
        target_nx = target;
        push      = 1'b0;
        pop       = 1'b0;
        ready     = 1'b0;
        valid     = 1'b0;

        case (state)
            RUN: begin
                ready = (count_r < CNT_W'(DEPTH));
                valid = (count_r != '0) && !q.flush;
                push  = q.f_valid && ready;
                pop   = valid && q.d_ready;
            end
            FILTER: begin
                // Drop wrong-path beats until the redirect target arrives.
                ready = 1'b1;
                push  = q.f_valid && (q.f_pc == target);
                if (push) begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = RUN;
            end
        endcase

        if (push) begin
            wr_ptr_nx = wr_ptr + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_nx = rd_ptr + PTR_W'(1);
        end
        count_nx = count_r + CNT_W'(push) - CNT_W'(pop);

        if (q.flush) begin
            push      = 1'b0;
            pop       = 1'b0;
            state_nx  = FILTER;
            target_nx = q.flush_pc;
            wr_ptr_nx = '0;
            rd_ptr_nx = '0;
            count_nx  = '0;
        end
    end

    iq_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WORD_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata ({q.f_instr, q.f_pc}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign q.f_ready = ready;
    assign q.d_valid = valid;
    assign q.d_instr = rd_data[2*WORD_W-1:WORD_W];
    assign q.d_pc    = rd_data[WORD_W-1:0];
    assign q.count   = count_r;

endmodule

// File: tb/tb_iqueue_tbp.sv
// Scoreboard bench for iqueue_tbp: directed fill, drain, stream, flush and reset cases.
module tb_iqueue_tbp;
    import iqueue_tbp_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    iqueue_tbp_if #(.DEPTH(4), .WORD_W(32)) bus ();

    iqueue_tbp #(.DEPTH(4), .WORD_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    function automatic word_t mk_instr(word_t pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(logic fv, word_t pc, logic dr);
        bus.f_valid = fv;
        bus.f_pc    = pc;
        bus.f_instr = mk_instr(pc);
        bus.d_ready = dr;
    endtask

    task automatic expect_push(word_t pc);
        exp_q.push_back({mk_instr(pc), pc});
    endtask

    // Monitor: every delivered head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.d_valid && bus.d_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mon_unexpected: got pc 0x%0h expected no delivery", bus.d_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("mon_pc", bus.d_pc, e[31:0]);
                chk("mon_instr", bus.d_instr, e[63:32]);
            end
        end
    end

    // Watchdog in case the run stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.flush_pc = '0;
        beat(1'b0, 32'h0, 1'b0);
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_dvalid", 32'(bus.d_valid), 32'd0);
        chk("rst_fready", 32'(bus.f_ready), 32'd1);
        chk("rst_count", 32'(bus.count), 32'd0);
        cyc();
        rst = 1'b0;

        // Fill to full with decode stalled.
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, word_t'(4 * k), 1'b0);
            expect_push(word_t'(4 * k));
            cyc();
        end
        beat(1'b1, 32'h10, 1'b0);
        @(negedge clk);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_fready", 32'(bus.f_ready), 32'd0);
        chk("fill_dvalid", 32'(bus.d_valid), 32'd1);
        chk("fill_dpc", bus.d_pc, 32'h0);
        cyc();
        @(negedge clk);
        chk("fill_5th_dropped", 32'(bus.count), 32'd4);
        cyc();

        // Drain in order.
        beat(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
        end
        @(negedge clk);
        chk("drain_dvalid", 32'(bus.d_valid), 32'd0);
        chk("drain_count", 32'(bus.count), 32'd0);
        cyc();
        @(negedge clk);
        chk("empty_pop_ignored", 32'(bus.count), 32'd0);
        cyc();

        // Streaming through two pointer wraps.
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, word_t'(32'h100 + 4 * k), 1'b1);
            expect_push(word_t'(32'h100 + 4 * k));
            if (k > 0) begin
                @(negedge clk);
                chk("stream_count", 32'(bus.count), 32'd1);
                chk("stream_pc", bus.d_pc, 32'h100 + 32'(4 * (k - 1)));
            end
            cyc();
        end
        beat(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("stream_last_pc", bus.d_pc, 32'h11C);
        cyc();
        @(negedge clk);
        chk("stream_end_count", 32'(bus.count), 32'd0);
        cyc();

        // Flush with simultaneous push and pop, then filter to 0x200.
        for (int k = 0; k < 3; k++) begin
            beat(1'b1, word_t'(32'h300 + 4 * k), 1'b0);
            cyc();
        end
        beat(1'b1, 32'h30C, 1'b1);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h200;
        exp_q.delete();
        @(negedge clk);
        chk("flush_dvalid", 32'(bus.d_valid), 32'd0);
        cyc();
        bus.flush = 1'b0;
        beat(1'b1, 32'h10, 1'b1);
        @(negedge clk);
        chk("post_flush_count", 32'(bus.count), 32'd0);
        chk("post_flush_dvalid", 32'(bus.d_valid), 32'd0);
        chk("filter_fready", 32'(bus.f_ready), 32'd1);
        cyc();
        beat(1'b1, 32'h14, 1'b1);
        @(negedge clk);
        chk("filter_drop_10", 32'(bus.count), 32'd0);
        cyc();
        beat(1'b1, 32'h200, 1'b1);
        expect_push(32'h200);
        @(negedge clk);
        chk("filter_drop_14", 32'(bus.count), 32'd0);
        cyc();
        beat(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("filter_hit_count", 32'(bus.count), 32'd1);
        chk("filter_hit_dvalid", 32'(bus.d_valid), 32'd1);
        chk("filter_hit_dpc", bus.d_pc, 32'h200);
        cyc();
        @(negedge clk);
        chk("filter_hit_drained", 32'(bus.count), 32'd0);
        cyc();

        // Back-to-back flushes: last target wins; idle filter holds.
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h400;
        beat(1'b0, 32'h0, 1'b0);
        cyc();
        bus.flush_pc = 32'h500;
        cyc();
        bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
        end
        @(negedge clk);
        chk("idle_fready", 32'(bus.f_ready), 32'd1);
        chk("idle_count", 32'(bus.count), 32'd0);
        cyc();
        beat(1'b1, 32'h400, 1'b1);
        @(negedge clk);
        chk("old_target_pending", 32'(bus.count), 32'd0);
        cyc();
        beat(1'b1, 32'h500, 1'b1);
        expect_push(32'h500);
        cyc();
        beat(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("old_target_dropped", 32'(bus.count), 32'd1);
        chk("new_target_dpc", bus.d_pc, 32'h500);
        cyc();

        // Reset together with flush: back to RUN and empty.
        for (int k = 0; k < 2; k++) begin
            beat(1'b1, word_t'(32'h700 + 4 * k), 1'b0);
            cyc();
        end
        rst          = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h600;
        beat(1'b0, 32'h0, 1'b0);
        cyc();
        rst       = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("rstfl_count", 32'(bus.count), 32'd0);
        chk("rstfl_fready", 32'(bus.f_ready), 32'd1);
        chk("rstfl_dvalid", 32'(bus.d_valid), 32'd0);
        beat(1'b1, 32'h40, 1'b0);
        expect_push(32'h40);
        cyc();
        beat(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        chk("rstfl_run_accept", 32'(bus.count), 32'd1);
        chk("rstfl_dpc", bus.d_pc, 32'h40);
        cyc();
        cyc();
        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
